fifo_burst_reader: RTL and testbench

Read-side consumer for the team's synchronous FIFO: on a start command it pops a programmed number of words from the FIFO and presents them on a valid/ready output stream. It absorbs the FIFO's one-cycle read latency with a 2-entry output buffer, so downstream backpressure never loses or duplicates data. It sits between the FIFO's `rd_en`/`dout`/`empty` pins and any stream sink (serializer, DMA, bus bridge).

---
 rtl/fifo_burst_reader.sv | 153 +++++++++++++++
 tb/tb_fifo_burst_reader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a programmed number of words from a synchronous FIFO
// and presents them on a valid/ready stream. A 2-entry buffer absorbs the FIFO's
// one-cycle read latency, so downstream backpressure never drops or repeats data.
// Optional feature: define FIFO_RD_CHECKSUM_EN to append an XOR checksum beat.
module fifo_burst_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    typedef enum logic [2:0] {StIdle, StRead, StDrain, StCsum, StFinish} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  pops_left_q;
    logic [LEN_W-1:0]  beats_left_q;
    logic [DATA_W-1:0] buf_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              inflight_q;
    logic [2:0]        occupancy;
    logic              start_ok;
    logic              data_xfer;
`ifdef FIFO_RD_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
`endif

    // Stream outputs, data-beat handshake and the pop decision
    always_comb begin
        start_ok  = (state_q == StIdle) && start;
        data_xfer = (count_q != 2'd0) && m_ready;
`ifdef FIFO_RD_CHECKSUM_EN
        // The checksum beat is driven directly; the buffer is empty by then
        m_valid = (count_q != 2'd0) || (state_q == StCsum);
        m_data  = (state_q == StCsum) ? csum_q : buf_q[rd_ptr_q];
        m_last  = (state_q == StCsum);
`else
        m_valid = (count_q != 2'd0);
        m_data  = buf_q[rd_ptr_q];
        m_last  = (count_q != 2'd0) && (beats_left_q == LEN_W'(1));
`endif
        // Words held or on their way, minus the one leaving this cycle
        occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, data_xfer};
        fifo_rd_en = (state_q == StRead) && !fifo_empty && (pops_left_q != '0) &&
                     (occupancy < 3'd2);
        busy = (state_q == StRead) || (state_q == StDrain) || (state_q == StCsum);
        done = (state_q == StFinish);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len != '0) begin
                        state_d = StRead;
                    end else begin
`ifdef FIFO_RD_CHECKSUM_EN
                        state_d = StCsum;
`else
                        state_d = StFinish;
`endif
                    end
                end
            end
            StRead: begin
                if (pops_left_q == '0) state_d = StDrain;
            end
            StDrain: begin
                if (data_xfer && (beats_left_q == LEN_W'(1))) begin
`ifdef FIFO_RD_CHECKSUM_EN
                    state_d = StCsum;
`else
                    state_d = StFinish;
`endif
                end
            end
            StCsum: begin
                if (m_ready) state_d = StFinish;
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Pop and beat countdowns; loaded on an accepted start, never wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pops_left_q  <= '0;
            beats_left_q <= '0;
        end else if (start_ok) begin
            pops_left_q  <= len;
            beats_left_q <= len;
        end else begin
            if (fifo_rd_en) pops_left_q <= pops_left_q - LEN_W'(1);
            if (data_xfer && (beats_left_q != '0)) beats_left_q <= beats_left_q - LEN_W'(1);
        end
    end

    // Two-entry output buffer: capture one cycle after each pop, in FIFO order
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= fifo_dout;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (data_xfer) rd_ptr_q <= ~rd_ptr_q;
            case ({inflight_q, data_xfer})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef FIFO_RD_CHECKSUM_EN
    // Running XOR of every captured data word in the current burst
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          csum_q <= '0;
        else if (start_ok)   csum_q <= '0;
        else if (inflight_q) csum_q <= csum_q ^ fifo_dout;
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT, a
// transaction-level model predicts the stream, and directed bursts pin literals.
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 8;
`ifdef FIFO_RD_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          busy, done, fifo_rd_en, m_valid, m_last;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b1;

    fifo_burst_reader #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // FIFO model: pops on rd_en seen before the edge, data valid the next cycle
    logic [DW-1:0] fq[$];
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          pop_now = 1'b0;

    initial forever begin
        @(posedge clk);
        if (pop_now && fq.size() > 0) fifo_dout <= fq.pop_front();
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    // Transaction model and per-cycle compare
    bit            busy_m = 0, done_m = 0, nbusy, ndone, xfer, stall_prev = 0;
    int            len_m = 0, pops_m = 0, beats_m = 0, total, first_rd_cyc = 0;
    int            bursts_done = 0, done_cyc = 0, data_beats;
    bit            seen_valid = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] beat_log[$];
    logic [DW-1:0] csum_m = '0, prev_data = '0, exp_w;
    logic          prev_last = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            busy_m = 0; done_m = 0; len_m = 0; pops_m = 0; beats_m = 0;
            exp_q.delete(); stall_prev = 0; pop_now = 0; seen_valid = 0;
        end else begin
            pop_now = fifo_rd_en;
            check("busy", 32'(busy), 32'(busy_m));
            check("done", 32'(done), 32'(done_m));
            if (done) done_cyc = cyc;
            if (done_m) begin
                check("pops_per_burst", pops_m, len_m);
                bursts_done++;
            end
            if (!busy_m) begin
                check("idle_valid", 32'(m_valid), 0);
                check("idle_rd_en", 32'(fifo_rd_en), 0);
            end
            if (fifo_rd_en) begin
                check("rd_en_while_empty", 32'(fifo_empty), 0);
                if (fq.size() > 0) exp_q.push_back(fq[0]);
                pops_m++;
                if (pops_m == 1) first_rd_cyc = cyc;
            end
            if (stall_prev) begin
                check("stall_valid", 32'(m_valid), 1);
                check("stall_data", 32'(m_data), 32'(prev_data));
                check("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && !seen_valid && len_m != 0)
                check("first_valid_latency", cyc - first_rd_cyc, 2);
            if (m_valid) seen_valid = 1;
            total = len_m + CS;
            xfer  = m_valid && m_ready;
            if (xfer && busy_m) begin
                if (beats_m >= total) begin
                    check("extra_beat", 32'(xfer), 0);
                end else if (beats_m < len_m) begin
                    check("beat_has_data", 32'(exp_q.size() > 0), 1);
                    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    check("beat_data", 32'(m_data), 32'(exp_w));
                    check("beat_last", 32'(m_last), (CS == 1) ? 0 : 32'(beats_m == len_m - 1));
                    csum_m ^= exp_w;
                end else begin
                    check("csum_data", 32'(m_data), 32'(csum_m));
                    check("csum_last", 32'(m_last), 1);
                end
                beat_log.push_back(m_data);
                beats_m++;
            end
            data_beats = (beats_m < len_m) ? beats_m : len_m;
            if (busy_m) check("outstanding_le_2", 32'(pops_m - data_beats <= 2), 1);
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            nbusy = busy_m;
            ndone = 0;
            if (busy_m && beats_m == total) begin
                nbusy = 0;
                ndone = 1;
            end
            if (start && !busy_m && !done_m) begin
                len_m = int'(len); pops_m = 0; beats_m = 0; csum_m = '0;
                exp_q.delete(); seen_valid = 0;
                if (len_m + CS == 0) ndone = 1;
                else nbusy = 1;
            end
            busy_m = nbusy;
            done_m = ndone;
        end
    end

    // Stimulus helpers; all called at posedge+1
    task automatic fifo_write(input logic [DW-1:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic do_start(input int l, output int s1);
        start = 1'b1;
        len   = LW'(l);
        @(posedge clk); #1;
        start = 1'b0;
        s1    = cyc;
    endtask

    task automatic wait_burst(input int target, input int limit);
        for (int i = 0; i < limit && bursts_done < target; i++) begin
            @(posedge clk); #1;
        end
        check("burst_completes", 32'(bursts_done >= target), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input int base, input int n,
                             input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                             input logic [DW-1:0] e2, input logic [DW-1:0] e3,
                             input logic [DW-1:0] e4);
        logic [DW-1:0] e[5];
        e = '{e0, e1, e2, e3, e4};
        check({name, "_count"}, beat_log.size() - base, n);
        for (int i = 0; i < n; i++)
            check(name, 32'(beat_log[base + i]), 32'(e[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, base, nb;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_en", 32'(fifo_rd_en), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_last", 32'(m_last), 0);
        check("rst_data", 32'(m_data), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Back-to-back burst, plus a start pulse while busy that must be ignored
        fifo_write(8'h11); fifo_write(8'h22); fifo_write(8'h33); fifo_write(8'h44);
        @(posedge clk); #1;
        base = beat_log.size(); nb = bursts_done;
        do_start(4, s1);
        start = 1'b1; len = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_burst(nb + 1, 40);
`ifdef FIFO_RD_CHECKSUM_EN
        check_log("t1_beats", base, 5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        check("t1_done_cycle", done_cyc - s1, 7);
`else
        check_log("t1_beats", base, 4, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
        check("t1_done_cycle", done_cyc - s1, 6);
`endif
        check("t1_pops", pops_m, 4);
        check("t1_idle_after", 32'(busy), 0);

        // Sink stalls five cycles after the first valid
        fifo_write(8'h11); fifo_write(8'h22); fifo_write(8'h33); fifo_write(8'h44);
        @(posedge clk); #1;
        base = beat_log.size(); nb = bursts_done;
        m_ready = 1'b0;
        do_start(4, s1);
        for (int i = 0; i < 20 && !m_valid; i++) begin
            @(posedge clk); #1;
        end
        check("t2_valid_seen", 32'(m_valid), 1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_data", 32'(m_data), 32'h11);
            @(posedge clk); #1;
        end
        check("t2_pops_during_stall", pops_m, 2);
        m_ready = 1'b1;
        wait_burst(nb + 1, 40);
        check_log("t2_beats", base, 4, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00);

        // FIFO empty at start; words trickle in
        base = beat_log.size(); nb = bursts_done;
        do_start(2, s1);
        repeat (4) @(posedge clk);
        #1;
        check("t3_no_pop_empty", pops_m, 0);
        fifo_write(8'hAA);
        repeat (2) @(posedge clk);
        #1;
        fifo_write(8'hBB);
        wait_burst(nb + 1, 40);
        check_log("t3_beats", base, 2, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00);
        check("t3_pops", pops_m, 2);

        // Zero-length burst
        base = beat_log.size(); nb = bursts_done;
        do_start(0, s1);
`ifdef FIFO_RD_CHECKSUM_EN
        check("t4_csum_valid", 32'(m_valid), 1);
        check("t4_csum_data", 32'(m_data), 0);
        check("t4_csum_last", 32'(m_last), 1);
`else
        check("t4_done_cycle1", 32'(done), 1);
        check("t4_no_valid", 32'(m_valid), 0);
`endif
        wait_burst(nb + 1, 20);
        check("t4_pops", pops_m, 0);
        check("t4_beats", beat_log.size() - base, CS);

        // Reset mid-burst after two beats, then a fresh burst
        for (int i = 1; i <= 8; i++) fifo_write(DW'(i));
        @(posedge clk); #1;
        base = beat_log.size(); nb = bursts_done;
        do_start(6, s1);
        for (int i = 0; i < 20 && beat_log.size() < base + 2; i++) begin
            @(posedge clk); #1;
        end
        check("t5_two_beats", beat_log.size() - base, 2);
        reset = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_done", 32'(done), 0);
        check("t5_rst_rd_en", 32'(fifo_rd_en), 0);
        check("t5_rst_valid", 32'(m_valid), 0);
        check("t5_rst_data", 32'(m_data), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_no_done_after_abort", bursts_done, nb);
        base = beat_log.size();
        do_start(2, s1);
        wait_burst(nb + 1, 40);
        check_log("t5_beats", base, 2, 8'h05, 8'h06, 8'h00, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
